zigbee_apb_arbiter: RTL and testbench

APB master and two-way round-robin arbiter sharing the single APB CPU-model slave between the ZigBee Tx and Rx interfaces. Each requester posts one read or write; the block sequences the APB setup/access phases, waits for PREADY (with timeout), and returns read data and a completion pulse to the winner. It sits between the Tx/Rx interface blocks and the APB slave, on PCLK.

---
 rtl/zigbee_apb_arbiter_pkg.sv | 38 +++
 rtl/apb_rr_arb2.sv | 42 ++++
 rtl/zigbee_apb_arbiter.sv | 158 +++++++++++++++
 tb/tb_zigbee_apb_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zigbee_apb_arbiter_pkg.sv
// Shared types for the ZigBee APB arbiter slice.
// Contents:
//   state_e         - transfer sequencer states
//   req_idx_e       - requester identity (Tx or Rx)
//   TIMEOUT_DEFAULT - default ACCESS wait limit
//   rr_pick()       - two-way round-robin choice given the last-served requester
package zigbee_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    REQ_TX = 1'b0,
    REQ_RX = 1'b1
  } req_idx_e;

  localparam int TIMEOUT_DEFAULT = 16;

  // On a tie the requester that was not served last wins. When nobody is
  // requesting the result is don't-care; the caller qualifies it.
  function automatic req_idx_e rr_pick(input logic req_tx, input logic req_rx,
                                       input req_idx_e last);
    req_idx_e pick;
    if (req_tx && req_rx) begin
      pick = (last == REQ_RX) ? REQ_TX : REQ_RX;
    end else if (req_tx) begin
      pick = REQ_TX;
    end else begin
      pick = REQ_RX;
    end
    return pick;
  endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter with a last-served pointer.
// Ports:
//   PCLK, PRESET      - clock, synchronous active-high reset
//   req_tx, req_rx    - request levels
//   upd, upd_idx      - strobe to record upd_idx (0 = Tx, 1 = Rx) as last served
//   win_idx           - current pick (0 = Tx, 1 = Rx), combinational
//   any_req           - at least one request is high
module apb_rr_arb2
  import zigbee_apb_pkg::*;
(
  input  logic PCLK,
  input  logic PRESET,
  input  logic req_tx,
  input  logic req_rx,
  input  logic upd,
  input  logic upd_idx,
  output logic win_idx,
  output logic any_req
);

  req_idx_e last_r;
  req_idx_e pick_s;

  // Last-served pointer; reset to Rx so that Tx wins the first tie.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      last_r <= REQ_RX;
    end else if (upd) begin
      last_r <= req_idx_e'(upd_idx);
    end else begin
      last_r <= last_r;
    end
  end

  // Winner selection from the current requests and the pointer.
  always_comb begin
    pick_s  = rr_pick(req_tx, req_rx, last_r);
    win_idx = (pick_s == REQ_RX);
    any_req = req_tx | req_rx;
  end

endmodule

// File: rtl/zigbee_apb_arbiter.sv
// APB master shared by the ZigBee Tx and Rx interfaces.
// Each requester holds i_*_REQ with its WR/ADDR/WDATA until its o_*_DONE
// pulse. The winner's fields are latched at IDLE->SETUP, the APB setup and
// access phases are sequenced, and PREADY is awaited for at most TIMEOUT
// ACCESS cycles before an error completion.
// Ports:
//   PCLK, PRESET                      - clock, synchronous active-high reset
//   i_TX_* / i_RX_*                   - requester command inputs
//   o_TX_DONE / o_RX_DONE, o_ERR      - completion and timeout pulses
//   o_TX_GNT / o_RX_GNT               - grant, SETUP through DONE
//   o_RDATA                           - data of last completed read
//   o_BUSY                            - sequencer not idle
//   PENABLE, PnR_W, PADDR, PWDATA     - APB master outputs
//   PREADY, PRDATA                    - APB slave responses
module zigbee_apb_arbiter
  import zigbee_apb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  i_TX_REQ,
  input  logic                  i_TX_WR,
  input  logic [ADDR_WIDTH-1:0] i_TX_ADDR,
  input  logic [DATA_WIDTH-1:0] i_TX_WDATA,
  input  logic                  i_RX_REQ,
  input  logic                  i_RX_WR,
  input  logic [ADDR_WIDTH-1:0] i_RX_ADDR,
  input  logic [DATA_WIDTH-1:0] i_RX_WDATA,
  output logic                  o_TX_DONE,
  output logic                  o_RX_DONE,
  output logic                  o_TX_GNT,
  output logic                  o_RX_GNT,
  output logic [DATA_WIDTH-1:0] o_RDATA,
  output logic                  o_ERR,
  output logic                  o_BUSY,
  output logic                  PENABLE,
  output logic                  PnR_W,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e           state_r;
  req_idx_e         winner_r;
  logic [CNT_W-1:0] cnt_r;
  logic             win_s;
  logic             any_s;
  req_idx_e         win_e_s;
  logic             upd_s;

  apb_rr_arb2 u_arb (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .req_tx  (i_TX_REQ),
    .req_rx  (i_RX_REQ),
    .upd     (upd_s),
    .upd_idx (winner_r == REQ_RX),
    .win_idx (win_s),
    .any_req (any_s)
  );

  // Arbiter glue: pointer advances while the completed transfer sits in DONE.
  always_comb begin
    win_e_s = req_idx_e'(win_s);
    upd_s   = (state_r == DONE);
  end

  // Transfer sequencer with all outputs registered.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r   <= IDLE;
      winner_r  <= REQ_TX;
      cnt_r     <= {CNT_W{1'b0}};
      PENABLE   <= 1'b0;
      PnR_W     <= 1'b0;
      PADDR     <= {ADDR_WIDTH{1'b0}};
      PWDATA    <= {DATA_WIDTH{1'b0}};
      o_TX_GNT  <= 1'b0;
      o_RX_GNT  <= 1'b0;
      o_TX_DONE <= 1'b0;
      o_RX_DONE <= 1'b0;
      o_ERR     <= 1'b0;
      o_RDATA   <= {DATA_WIDTH{1'b0}};
      o_BUSY    <= 1'b0;
    end else begin
      // Completion pulses last only the DONE cycle.
      o_TX_DONE <= 1'b0;
      o_RX_DONE <= 1'b0;
      o_ERR     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_s) begin
            winner_r <= win_e_s;
            PnR_W    <= (win_e_s == REQ_RX) ? i_RX_WR    : i_TX_WR;
            PADDR    <= (win_e_s == REQ_RX) ? i_RX_ADDR  : i_TX_ADDR;
            PWDATA   <= (win_e_s == REQ_RX) ? i_RX_WDATA : i_TX_WDATA;
            o_TX_GNT <= (win_e_s == REQ_TX);
            o_RX_GNT <= (win_e_s == REQ_RX);
            o_BUSY   <= 1'b1;
            state_r  <= SETUP;
          end else begin
            state_r  <= IDLE;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state_r <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PENABLE   <= 1'b0;
            if (!PnR_W) begin
              o_RDATA <= PRDATA;
            end else begin
              o_RDATA <= o_RDATA;
            end
            o_TX_DONE <= (winner_r == REQ_TX);
            o_RX_DONE <= (winner_r == REQ_RX);
            state_r   <= DONE;
          end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
            // Counter starts at 0 on the first ACCESS cycle, so PENABLE has
            // been high for exactly TIMEOUT cycles here.
            PENABLE   <= 1'b0;
            o_RDATA   <= {DATA_WIDTH{1'b1}};
            o_ERR     <= 1'b1;
            o_TX_DONE <= (winner_r == REQ_TX);
            o_RX_DONE <= (winner_r == REQ_RX);
            state_r   <= DONE;
          end else begin
            cnt_r     <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          o_TX_GNT <= 1'b0;
          o_RX_GNT <= 1'b0;
          o_BUSY   <= 1'b0;
          cnt_r    <= {CNT_W{1'b0}};
          state_r  <= IDLE;
        end
        default: begin
          PENABLE  <= 1'b0;
          o_TX_GNT <= 1'b0;
          o_RX_GNT <= 1'b0;
          o_BUSY   <= 1'b0;
          cnt_r    <= {CNT_W{1'b0}};
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zigbee_apb_arbiter.sv
// Scoreboard bench for zigbee_apb_arbiter: stimulus pushes hand-computed
// expectations, a negedge monitor checks SETUP/ACCESS fields and completions.
module tb_zigbee_apb_arbiter;

  logic       PCLK;
  logic       PRESET;
  logic       i_TX_REQ, i_TX_WR, i_RX_REQ, i_RX_WR;
  logic [1:0] i_TX_ADDR, i_RX_ADDR;
  logic [7:0] i_TX_WDATA, i_RX_WDATA;
  logic       o_TX_DONE, o_RX_DONE, o_TX_GNT, o_RX_GNT, o_ERR, o_BUSY;
  logic [7:0] o_RDATA;
  logic       PENABLE, PnR_W, PREADY;
  logic [1:0] PADDR;
  logic [7:0] PWDATA, PRDATA;

  zigbee_apb_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .i_TX_REQ(i_TX_REQ), .i_TX_WR(i_TX_WR), .i_TX_ADDR(i_TX_ADDR), .i_TX_WDATA(i_TX_WDATA),
    .i_RX_REQ(i_RX_REQ), .i_RX_WR(i_RX_WR), .i_RX_ADDR(i_RX_ADDR), .i_RX_WDATA(i_RX_WDATA),
    .o_TX_DONE(o_TX_DONE), .o_RX_DONE(o_RX_DONE), .o_TX_GNT(o_TX_GNT), .o_RX_GNT(o_RX_GNT),
    .o_RDATA(o_RDATA), .o_ERR(o_ERR), .o_BUSY(o_BUSY),
    .PENABLE(PENABLE), .PnR_W(PnR_W), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // ---------------- slave model ----------------
  logic [7:0] mem [4];
  logic       mem_init = 1'b0;
  int         lat  = 0;      // ACCESS cycles before PREADY
  logic       hang = 1'b0;   // never assert PREADY
  int         acc  = 0;

  assign PREADY = PENABLE && !hang && (acc >= lat);
  assign PRDATA = mem[PADDR];

  always @(posedge PCLK) begin
    if (!mem_init) begin
      mem[0] <= 8'h01; mem[1] <= 8'h02; mem[2] <= 8'hFE; mem[3] <= 8'hFF;
      mem_init <= 1'b1;
    end else if (PENABLE && PREADY && PnR_W) begin
      mem[PADDR] <= PWDATA;
    end
    if (PENABLE && !PREADY) acc <= acc + 1;
    else acc <= 0;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic       who;     // 0 = Tx, 1 = Rx
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         en;      // expected PENABLE-high cycles
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int   en_run = 0, last_run = 0, low_run = 100;
  logic prev_en = 1'b0, seen_rise = 1'b0;

  always @(negedge PCLK) begin
    if (PRESET) begin
      en_run = 0; prev_en = 1'b0; low_run = 100;
    end else begin
      if (PENABLE) begin
        if (!prev_en) begin
          if (seen_rise) chk("penable_low_gap_ge2", 32'(low_run >= 2), 32'd1);
          seen_rise = 1'b1;
        end
        en_run++; low_run = 0;
      end else begin
        if (en_run != 0) begin last_run = en_run; en_run = 0; end
        low_run++;
      end
      prev_en = PENABLE;

      if ((o_TX_GNT || o_RX_GNT) && !o_TX_DONE && !o_RX_DONE) begin
        if (exp_q.size() == 0) begin
          chk("grant_without_request", 32'd1, 32'd0);
        end else if (!PENABLE) begin
          chk("setup_gnt", {30'd0, o_RX_GNT, o_TX_GNT}, exp_q[0].who ? 32'd2 : 32'd1);
          chk("setup_pwrite", 32'(PnR_W), 32'(exp_q[0].wr));
          chk("setup_paddr", 32'(PADDR), 32'(exp_q[0].addr));
          chk("setup_busy", 32'(o_BUSY), 32'd1);
          if (exp_q[0].wr) chk("setup_pwdata", 32'(PWDATA), 32'(exp_q[0].wdata));
        end else begin
          chk("access_paddr_held", 32'(PADDR), 32'(exp_q[0].addr));
        end
      end

      if (o_TX_DONE || o_RX_DONE) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {30'd0, o_RX_DONE, o_TX_DONE}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_who", {30'd0, o_RX_DONE, o_TX_DONE}, e.who ? 32'd2 : 32'd1);
          chk("done_err", 32'(o_ERR), 32'(e.err));
          chk("done_rdata", 32'(o_RDATA), 32'(e.rdata));
          chk("penable_cycles", 32'(last_run), 32'(e.en));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic who, input logic wr, input logic [1:0] addr,
                       input logic [7:0] wdata, input logic [7:0] rdata,
                       input logic err, input int en);
    exp_t e;
    e.who = who; e.wr = wr; e.addr = addr; e.wdata = wdata;
    e.rdata = rdata; e.err = err; e.en = en;
    exp_q.push_back(e);
    if (who) begin
      i_RX_REQ = 1'b1; i_RX_WR = wr; i_RX_ADDR = addr; i_RX_WDATA = wdata;
    end else begin
      i_TX_REQ = 1'b1; i_TX_WR = wr; i_TX_ADDR = addr; i_TX_WDATA = wdata;
    end
  endtask

  task automatic wait_done(input logic who, input string name);
    bit got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge PCLK);
      got = who ? o_RX_DONE : o_TX_DONE;
    end
    if (!got) chk({name, "_done_timeout"}, 32'd0, 32'd1);
    if (who) i_RX_REQ = 1'b0; else i_TX_REQ = 1'b0;
  endtask

  task automatic wait_penable(input string name);
    bit got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge PCLK);
      got = PENABLE;
    end
    if (!got) chk({name, "_penable_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge PCLK);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    PRESET = 1'b1;
    i_TX_REQ = 1'b0; i_TX_WR = 1'b0; i_TX_ADDR = 2'd0; i_TX_WDATA = 8'h00;
    i_RX_REQ = 1'b0; i_RX_WR = 1'b0; i_RX_ADDR = 2'd0; i_RX_WDATA = 8'h00;
    idle_cycles(3);
    chk("reset_penable", 32'(PENABLE), 32'd0);
    chk("reset_apb_regs", {21'd0, PnR_W, PADDR, PWDATA}, 32'd0);
    chk("reset_ctrl", {26'd0, o_TX_GNT, o_RX_GNT, o_TX_DONE, o_RX_DONE, o_ERR, o_BUSY}, 32'd0);
    chk("reset_rdata", 32'(o_RDATA), 32'd0);
    PRESET = 1'b0;
    idle_cycles(2);

    // Tx read addr 2, zero-wait slave
    lat = 0;
    issue(1'b0, 1'b0, 2'd2, 8'h00, 8'hFE, 1'b0, 1);
    wait_done(1'b0, "tx_read2");
    idle_cycles(2);

    // Rx write 0x5A to addr 1 (o_RDATA keeps 0xFE), then Tx reads it back
    lat = 2;
    issue(1'b1, 1'b1, 2'd1, 8'h5A, 8'hFE, 1'b0, 3);
    wait_done(1'b1, "rx_write1");
    lat = 1;
    issue(1'b0, 1'b0, 2'd1, 8'h00, 8'h5A, 1'b0, 2);
    wait_done(1'b0, "tx_read1");
    idle_cycles(2);

    // Reset restores pointer to Rx-last and clears o_RDATA
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("reset_pulse_rdata", 32'(o_RDATA), 32'd0);
    PRESET = 1'b0;
    idle_cycles(1);

    // Tie: Tx first, Rx granted on next IDLE
    lat = 0;
    issue(1'b0, 1'b0, 2'd0, 8'h00, 8'h01, 1'b0, 1);
    issue(1'b1, 1'b0, 2'd3, 8'h00, 8'hFF, 1'b0, 1);
    wait_done(1'b0, "tie1_tx");
    wait_done(1'b1, "tie1_rx");
    idle_cycles(2);

    // Tx served alone, so the next tie goes to Rx
    issue(1'b0, 1'b0, 2'd2, 8'h00, 8'hFE, 1'b0, 1);
    wait_done(1'b0, "tx_alone");
    idle_cycles(2);
    issue(1'b1, 1'b0, 2'd3, 8'h00, 8'hFF, 1'b0, 1);
    issue(1'b0, 1'b0, 2'd0, 8'h00, 8'h01, 1'b0, 1);
    wait_done(1'b1, "tie2_rx");
    wait_done(1'b0, "tie2_tx");
    idle_cycles(2);

    // Timeout: PREADY never rises
    hang = 1'b1;
    issue(1'b0, 1'b0, 2'd1, 8'h00, 8'hFF, 1'b1, 16);
    wait_done(1'b0, "timeout");
    hang = 1'b0;
    idle_cycles(2);

    // Reset during ACCESS aborts the transfer without a done pulse
    lat = 3;
    issue(1'b0, 1'b0, 2'd2, 8'h00, 8'hFE, 1'b0, 4);
    wait_penable("abort");
    PRESET = 1'b1;
    exp_q.delete();
    @(posedge PCLK); #1;
    chk("abort_penable", 32'(PENABLE), 32'd0);
    chk("abort_gnt_done", {28'd0, o_TX_GNT, o_RX_GNT, o_TX_DONE, o_RX_DONE}, 32'd0);
    chk("abort_busy", 32'(o_BUSY), 32'd0);
    @(negedge PCLK);
    issue(1'b0, 1'b0, 2'd2, 8'h00, 8'hFE, 1'b0, 4);
    PRESET = 1'b0;
    wait_done(1'b0, "after_abort");
    idle_cycles(2);

    // Tx drops request and changes address mid-ACCESS
    lat = 4;
    issue(1'b0, 1'b0, 2'd3, 8'h00, 8'hFF, 1'b0, 5);
    wait_penable("drop");
    i_TX_REQ = 1'b0; i_TX_ADDR = 2'd0;
    wait_done(1'b0, "drop");
    idle_cycles(10);
    chk("final_idle_busy", 32'(o_BUSY), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
